fir_ctrl: RTL and testbench

Sequencing controller for the 11-tap FIR engine. It owns the ap_start/ap_done/ap_idle handshake and the circular-buffer pointer, and generates every tap-RAM and data-RAM address. It also drives the stream-side ready/valid and the MAC strobes to the multiply-accumulate datapath. The register-file block sits above it; the datapath (MAC, BRAM data muxing) sits below it.

---
 rtl/fir_ctrl_if.sv | 39 +++
 rtl/fir_ctrl.sv | 104 ++++++++++
 tb/tb_fir_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_if.sv
// fir_ctrl_if: control, stream and BRAM-sequencing signals between fir_ctrl and its neighbours
interface fir_ctrl_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pLEN_WIDTH  = 32
);
    logic                   ap_start_set;
    logic                   ap_ctrl_rd;
    logic [pLEN_WIDTH-1:0]  data_length;
    logic                   ap_start;
    logic                   ap_done;
    logic                   ap_idle;
    logic                   err_tlast;
    logic                   tap_own;
    logic                   ss_tvalid;
    logic                   ss_tlast;
    logic                   ss_tready;
    logic                   sm_tvalid;
    logic                   sm_tready;
    logic                   sm_tlast;
    logic                   ram_en;
    logic                   data_we;
    logic                   data_clr;
    logic [pADDR_WIDTH-1:0] tap_addr;
    logic [pADDR_WIDTH-1:0] data_addr;
    logic                   mac_clr;
    logic                   mac_en;

    modport master (
        input  ap_start_set, ap_ctrl_rd, data_length, ss_tvalid, ss_tlast, sm_tready,
        output ap_start, ap_done, ap_idle, err_tlast, tap_own, ss_tready, sm_tvalid, sm_tlast,
               ram_en, data_we, data_clr, tap_addr, data_addr, mac_clr, mac_en
    );

    modport slave (
        output ap_start_set, ap_ctrl_rd, data_length, ss_tvalid, ss_tlast, sm_tready,
        input  ap_start, ap_done, ap_idle, err_tlast, tap_own, ss_tready, sm_tvalid, sm_tlast,
               ram_en, data_we, data_clr, tap_addr, data_addr, mac_clr, mac_en
    );
endinterface

// File: rtl/fir_ctrl.sv
// fir_ctrl: FIR sequencing controller -- ap handshake, circular-buffer pointer, BRAM addressing, MAC strobes
module fir_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int Tape_Num    = 11,
    parameter int pLEN_WIDTH  = 32
) (
    input logic        axis_clk,
    input logic        axis_rst,
    fir_ctrl_if.master bus
);
    localparam int IW = $clog2(Tape_Num);
    localparam logic [IW-1:0] LAST = IW'(Tape_Num - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_IN, MAC, FLUSH, OUT, DONE} state_t;

    state_t                state_q;
    logic [IW-1:0]         ptr_q, k_q, k_d, dat_idx;
    logic [pLEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ap_start_q, ap_done_q, ap_idle_q, err_q, mac_en_q, mac_clr_q;
    logic                  take, last, to_done, start_ok;

    assign take     = state_q == WAIT_IN && bus.ss_tvalid;
    assign last     = cnt_q == bus.data_length;
    assign cnt_d    = cnt_q + pLEN_WIDTH'(1);
    assign k_d      = k_q == LAST ? '0 : k_q + IW'(1);
    assign start_ok = state_q == IDLE && !ap_start_q && bus.ap_start_set;
    assign to_done  = (state_q == CLEAR && k_q == LAST && bus.data_length == '0) ||
                      (state_q == OUT && bus.sm_tready && last);
    // newest sample sits at ptr; tap k pairs with the sample k steps older
    assign dat_idx  = state_q == CLEAR ? k_q :
                      state_q == MAC   ? (ptr_q >= k_q ? ptr_q - k_q : ptr_q + (LAST - k_q) + IW'(1)) :
                      ptr_q;

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            ap_start_q <= 1'b0;
            ap_done_q  <= 1'b0;
            ap_idle_q  <= 1'b1;
            err_q      <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
        end else begin
            mac_en_q  <= state_q == MAC;
            mac_clr_q <= state_q == MAC && k_q == '0;
            ap_done_q <= to_done ? 1'b1 : (bus.ap_ctrl_rd || start_ok) ? 1'b0 : ap_done_q;
            if (to_done) ap_idle_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (ap_start_q) begin
                        ap_start_q <= 1'b0;
                        ap_idle_q  <= 1'b0;
                        ptr_q      <= '0;
                        cnt_q      <= '0;
                        k_q        <= '0;
                        state_q    <= CLEAR;
                    end else if (bus.ap_start_set) begin
                        ap_start_q <= 1'b1;
                        err_q      <= 1'b0;
                    end
                end
                CLEAR: begin
                    k_q <= k_d;
                    if (k_q == LAST) state_q <= bus.data_length == '0 ? DONE : WAIT_IN;
                end
                WAIT_IN: if (bus.ss_tvalid) begin
                    cnt_q   <= cnt_d;
                    k_q     <= '0;
                    state_q <= MAC;
                    if (bus.ss_tlast && cnt_d < bus.data_length) err_q <= 1'b1;
                end
                MAC: begin
                    k_q <= k_d;
                    if (k_q == LAST) state_q <= FLUSH;
                end
                FLUSH: state_q <= OUT;
                OUT: if (bus.sm_tready) begin
                    ptr_q   <= ptr_q == LAST ? '0 : ptr_q + IW'(1);
                    state_q <= last ? DONE : WAIT_IN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ap_start  = ap_start_q;
    assign bus.ap_done   = ap_done_q;
    assign bus.ap_idle   = ap_idle_q;
    assign bus.err_tlast = err_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.tap_own   = state_q != IDLE;
    assign bus.ss_tready = state_q == WAIT_IN;
    assign bus.sm_tvalid = state_q == OUT;
    assign bus.sm_tlast  = state_q == OUT && last;
    assign bus.ram_en    = state_q == CLEAR || state_q == MAC || take;
    assign bus.data_we   = state_q == CLEAR || take;
    assign bus.data_clr  = state_q == CLEAR;
    assign bus.tap_addr  = state_q == MAC ? pADDR_WIDTH'({k_q, 2'b00}) : '0;
    assign bus.data_addr = pADDR_WIDTH'({dat_idx, 2'b00});
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: run table plus negedge monitor with latency/tlast scoreboard and address model
module tb_fir_ctrl;
    localparam int N = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_ctrl_if #(.pADDR_WIDTH(12), .pLEN_WIDTH(32)) bus ();
    fir_ctrl #(.pADDR_WIDTH(12), .Tape_Num(N), .pLEN_WIDTH(32)) dut (
        .axis_clk(clk),
        .axis_rst(rst),
        .bus     (bus)
    );

    typedef struct {int len; int tlast_at; int stall_at; bit poke; bit exp_err; int exp_outs;} run_t;
    typedef struct {int due; bit last;} exp_t;

    exp_t sb[$];
    int   errors = 0, checks = 0, cyc = 0, hs_t = -100, cur_p = 0, in_idx = 0, clr_i = 0, n_out = 0, cur_len = 0;
    bit   out_seen = 0, held_last = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: everything sampled at negedge, mid-cycle
    always @(negedge clk) begin
        int   d;
        exp_t e;
        cyc++;
        if (!bus.tap_own) begin
            clr_i  = 0;
            in_idx = 0;
            n_out  = 0;
        end
        if (bus.data_clr) begin
            check("clr_we", {31'd0, bus.data_we & bus.ram_en}, 1);
            check("clr_addr", bus.data_addr, clr_i * 4);
            clr_i++;
        end
        d = cyc - hs_t;
        if (d >= 1 && d <= N) begin
            check("mac_en_we", {30'd0, bus.ram_en, bus.data_we}, 2);
            check("mac_tap_addr", bus.tap_addr, (d - 1) * 4);
            check("mac_data_addr", bus.data_addr, ((cur_p - (d - 1) + N) % N) * 4);
            check("mac_ss_tready", bus.ss_tready, 0);
        end
        check("mac_en", bus.mac_en, d >= 2 && d <= N + 1);
        check("mac_clr", bus.mac_clr, d == 2);
        if (bus.ss_tvalid && bus.ss_tready) begin
            check("in_strobe", {31'd0, bus.data_we & bus.ram_en & !bus.data_clr}, 1);
            check("in_addr", bus.data_addr, (in_idx % N) * 4);
            cur_p = in_idx % N;
            sb.push_back('{cyc + N + 2, (in_idx + 1) == cur_len});
            in_idx++;
            hs_t = cyc;
        end
        if (bus.sm_tvalid && !out_seen) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_latency", cyc, e.due);
                check("out_tlast", bus.sm_tlast, e.last);
            end
            out_seen  = 1;
            held_last = bus.sm_tlast;
        end else if (bus.sm_tvalid) begin
            check("hold_tlast", bus.sm_tlast, held_last);
            check("hold_ss_tready", bus.ss_tready, 0);
        end
        if (bus.sm_tvalid && bus.sm_tready) begin
            out_seen = 0;
            n_out++;
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation still running at t=%0t, want finished", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        run_t runs[4];
        run_t t;
        int   w;
        runs[0] = '{3, 0, 0, 1'b0, 1'b0, 3};
        runs[1] = '{12, 0, 0, 1'b0, 1'b0, 12};
        runs[2] = '{4, 2, 1, 1'b1, 1'b1, 4};
        runs[3] = '{0, 0, 0, 1'b0, 1'b0, 0};
        bus.ap_start_set = 0;
        bus.ap_ctrl_rd   = 0;
        bus.data_length  = 0;
        bus.ss_tvalid    = 0;
        bus.ss_tlast     = 0;
        bus.sm_tready    = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_idle", bus.ap_idle, 1);
        check("rst_start", bus.ap_start, 0);
        check("rst_done", bus.ap_done, 0);
        check("rst_ss_tready", bus.ss_tready, 0);
        check("rst_sm_tvalid", bus.sm_tvalid, 0);
        check("rst_tap_own", bus.tap_own, 0);
        check("rst_err", bus.err_tlast, 0);
        check("rst_data_addr", bus.data_addr, 0);
        @(posedge clk);
        #1 rst = 0;
        for (int r = 0; r < 4; r++) begin
            t = runs[r];
            cur_len = t.len;
            bus.data_length = 32'(t.len);
            bus.ap_start_set = 1;
            @(posedge clk);
            #1 bus.ap_start_set = 0;
            @(negedge clk);
            check("start_set", bus.ap_start, 1);
            check("start_done_clr", bus.ap_done, 0);
            check("start_idle", bus.ap_idle, 1);
            @(negedge clk);
            check("run_start", bus.ap_start, 0);
            check("run_idle", bus.ap_idle, 0);
            check("run_tap_own", bus.tap_own, 1);
            for (int i = 0; i < t.len; i++) begin
                @(posedge clk);
                #1;
                bus.ss_tvalid = 1;
                bus.ss_tlast  = (i + 1 == t.tlast_at);
                w = 0;
                @(negedge clk);
                while (!bus.ss_tready && w < 60) begin
                    @(negedge clk);
                    w++;
                end
                check("in_ready_wait", bus.ss_tready, 1);
                @(posedge clk);
                #1;
                bus.ss_tvalid = 0;
                bus.ss_tlast  = 0;
                if (t.poke && i == 0) begin
                    bus.ap_start_set = 1;
                    @(posedge clk);
                    #1 bus.ap_start_set = 0;
                    @(negedge clk);
                    check("start_ignored", bus.ap_start, 0);
                end
                w = 0;
                @(negedge clk);
                while (!bus.sm_tvalid && w < 60) begin
                    @(negedge clk);
                    w++;
                end
                check("out_valid_wait", bus.sm_tvalid, 1);
                if (i + 1 == t.stall_at) repeat (5) @(negedge clk);
                @(posedge clk);
                #1 bus.sm_tready = 1;
                @(posedge clk);
                #1 bus.sm_tready = 0;
            end
            w = 0;
            @(negedge clk);
            while (!bus.ap_done && w < 60) begin
                @(negedge clk);
                w++;
            end
            check("done_set", bus.ap_done, 1);
            check("done_idle", bus.ap_idle, 1);
            check("done_err", bus.err_tlast, t.exp_err);
            check("done_outputs", n_out, t.exp_outs);
            check("done_clears", clr_i, N);
            check("done_sb_empty", sb.size(), 0);
            @(posedge clk);
            #1 bus.ap_ctrl_rd = 1;
            @(posedge clk);
            #1 bus.ap_ctrl_rd = 0;
            @(negedge clk);
            check("rd_done_clr", bus.ap_done, 0);
            check("rd_idle", bus.ap_idle, 1);
            check("rd_tap_own", bus.tap_own, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
